// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared encodings for the ALU issue unit: function codes, flag
//            and status bit positions, exception codes, FSM states and the
//            request screening helper.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Function code field
    localparam int FUNC_W = 3;
    localparam logic [FUNC_W-1:0] FUNC_ADD     = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_SUB     = 3'b001;
    localparam logic [FUNC_W-1:0] FUNC_MUL     = 3'b010;
    localparam logic [FUNC_W-1:0] FUNC_DIV     = 3'b011;
    localparam logic [FUNC_W-1:0] FUNC_AND     = 3'b100;
    localparam logic [FUNC_W-1:0] FUNC_OR      = 3'b101;
    localparam logic [FUNC_W-1:0] FUNC_NOT     = 3'b110;
    localparam logic [FUNC_W-1:0] FUNC_ILLEGAL = 3'b111;

    // Captured flag vector {overflow, equals, above, zero}
    localparam int FLAG_W        = 4;
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_ABOVE    = 1;
    localparam int FLAG_EQUALS   = 2;
    localparam int FLAG_OVERFLOW = 3;

    // Sticky status {exc_div0, exc_illegal, overflow, equals, above, zero}
    localparam int STATUS_W         = 6;
    localparam int STAT_EXC_ILLEGAL = 4;
    localparam int STAT_EXC_DIV0    = 5;

    // Exception codes
    localparam int EXC_W = 2;
    localparam logic [EXC_W-1:0] EXC_NONE    = 2'b00;
    localparam logic [EXC_W-1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [EXC_W-1:0] EXC_DIV0    = 2'b10;

    // Issue FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_EXC   = 3'd4
    } state_t;

    // Classify a request before it reaches the ALU; EXC_NONE means issue it.
    function automatic logic [EXC_W-1:0] screen_request(
        input logic [FUNC_W-1:0] func,
        input logic              op2_is_zero
    );
        logic [EXC_W-1:0] code;
        code = EXC_NONE;
        if (func == FUNC_ILLEGAL) begin
            code = EXC_ILLEGAL;
        end else if ((func == FUNC_DIV) && op2_is_zero) begin
            code = EXC_DIV0;
        end
        return code;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : alu_settle_counter
// Brief    : Loadable down-counter that stops at zero; o_done is high while
//            the count is zero. Times the operand settle window.
// Revision : 1.0 - initial release
// ============================================================================
module alu_settle_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Load takes priority; otherwise count down while enabled, saturating at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule : alu_settle_counter
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Initiator side of the ALU operand/function interface. Accepts
//            requests over valid/ready, screens illegal functions and divide
//            by zero, drives the combinational ALU for a settle window, then
//            captures result/flags and strobes writeback or exception.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    // request from control unit
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FUNC_W-1:0]     req_func,
    input  logic [WIDTH-1:0]      req_op1,
    input  logic [WIDTH-1:0]      req_op2,
    input  logic [REG_ADDR_W-1:0] req_rd,
    // combinational ALU
    output logic [WIDTH-1:0]      alu_op1,
    output logic [WIDTH-1:0]      alu_op2,
    output logic [FUNC_W-1:0]     alu_func,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_equals,
    input  logic                  alu_above,
    input  logic                  alu_zero,
    // writeback
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [WIDTH-1:0]      wb_data,
    output logic [FLAG_W-1:0]     wb_flags,
    // exceptions and status
    output logic                  exc_valid,
    output logic [EXC_W-1:0]      exc_code,
    output logic [STATUS_W-1:0]   status,
    input  logic                  status_clr
);

    // Counter holds values 0 .. SETTLE_CYCLES-1
    localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);

    state_t r_state;
    state_t w_state_next;

    logic                  w_accept;
    logic                  w_cnt_load;
    logic                  w_cnt_en;
    logic                  w_cnt_done;
    logic                  w_capture;
    logic                  w_wb_valid;
    logic                  w_exc_valid;
    logic [EXC_W-1:0]      w_screen;
    logic [FLAG_W-1:0]     w_alu_flags;
    logic [STATUS_W-1:0]   w_status_set;
    logic [STATUS_W-1:0]   w_status_next;

    logic                  r_req_ready;
    logic [FUNC_W-1:0]     r_func;
    logic [WIDTH-1:0]      r_op1;
    logic [WIDTH-1:0]      r_op2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [EXC_W-1:0]      r_exc_code;
    logic [WIDTH-1:0]      r_alu_op1;
    logic [WIDTH-1:0]      r_alu_op2;
    logic [FUNC_W-1:0]     r_alu_func;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [WIDTH-1:0]      r_wb_data;
    logic [FLAG_W-1:0]     r_wb_flags;
    logic [STATUS_W-1:0]   r_status;

    assign w_screen = screen_request(req_func, (req_op2 == '0));

    // State register; synchronous reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state controls. Strobes are masked by reset so an
    // aborted operation never emits writeback or exception.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        w_capture    = 1'b0;
        w_wb_valid   = 1'b0;
        w_exc_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_screen == EXC_NONE) ? ST_ISSUE : ST_EXC;
                end
            end
            ST_ISSUE: begin
                w_cnt_load   = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_cnt_en = 1'b1;
                if (w_cnt_done) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_WB;
                end
            end
            ST_WB: begin
                w_wb_valid   = ~reset;
                w_state_next = ST_IDLE;
            end
            ST_EXC: begin
                w_exc_valid  = ~reset;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Settle window timer, loaded in ISSUE and counted down in WAIT.
    alu_settle_counter #(
        .CNT_W (c_cnt_w)
    ) u_settle_cnt (
        .clk          (clk),
        .rst          (reset),
        .i_load       (w_cnt_load),
        .i_en         (w_cnt_en),
        .i_load_value (c_settle_load),
        .o_done       (w_cnt_done)
    );

    // Flags are taken verbatim from the ALU; nothing is recomputed locally.
    always_comb begin
        w_alu_flags                = '0;
        w_alu_flags[FLAG_OVERFLOW] = alu_overflow;
        w_alu_flags[FLAG_EQUALS]   = alu_equals;
        w_alu_flags[FLAG_ABOVE]    = alu_above;
        w_alu_flags[FLAG_ZERO]     = alu_zero;
    end

    // Sticky status: a clear and a set in the same cycle leaves the set bit.
    always_comb begin
        w_status_set = '0;
        if (r_state == ST_WB) begin
            w_status_set[FLAG_W-1:0] = r_wb_flags;
        end else if (r_state == ST_EXC) begin
            if (r_exc_code == EXC_DIV0) begin
                w_status_set[STAT_EXC_DIV0] = 1'b1;
            end else begin
                w_status_set[STAT_EXC_ILLEGAL] = 1'b1;
            end
        end
        w_status_next = (status_clr ? '0 : r_status) | w_status_set;
    end

    // Request latch, ALU drive, result capture, ready and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_ready <= 1'b0;
            r_func      <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rd        <= '0;
            r_exc_code  <= '0;
            r_alu_op1   <= '0;
            r_alu_op2   <= '0;
            r_alu_func  <= '0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_wb_flags  <= '0;
            r_status    <= '0;
        end else begin
            // ready is registered so it rises one cycle after reset releases
            r_req_ready <= (w_state_next == ST_IDLE);
            if (w_accept) begin
                r_func <= req_func;
                r_op1  <= req_op1;
                r_op2  <= req_op2;
                r_rd   <= req_rd;
                if (w_screen != EXC_NONE) begin
                    r_exc_code <= w_screen;
                end
            end
            // ALU inputs only change on ISSUE, so they hold through WAIT/EXC
            if (r_state == ST_ISSUE) begin
                r_alu_op1  <= r_op1;
                r_alu_op2  <= r_op2;
                r_alu_func <= r_func;
            end
            if (w_capture) begin
                r_wb_data  <= alu_result;
                r_wb_flags <= w_alu_flags;
                r_wb_rd    <= r_rd;
            end
            r_status <= w_status_next;
        end
    end

    assign req_ready = r_req_ready;
    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;
    assign alu_func  = r_alu_func;
    assign wb_valid  = w_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign wb_flags  = r_wb_flags;
    assign exc_valid = w_exc_valid;
    assign exc_code  = r_exc_code;
    assign status    = r_status;

endmodule : alu_issue_unit
`default_nettype wire
